// File: rtl/wallace_mult_rr_arbiter.sv
// Round-robin arbiter sharing one combinational 8x8 Wallace-tree multiplier
// between NUM_REQ requesters, with registered issue and output stages.

module Wallace_Tree_Multiplier_8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  // 3:2 compressor: sum and shifted carry vectors
  function automatic logic [15:0] csa_sum(input logic [15:0] x, input logic [15:0] y,
                                          input logic [15:0] z);
    csa_sum = x ^ y ^ z;
  endfunction

  function automatic logic [15:0] csa_carry(input logic [15:0] x, input logic [15:0] y,
                                            input logic [15:0] z);
    logic [15:0] maj;
    maj = (x & y) | (x & z) | (y & z);
    csa_carry = {maj[14:0], 1'b0};
  endfunction

  logic [15:0] pp_s [8];
  logic [15:0] s0_s, c0_s, s1_s, c1_s, s2_s, c2_s, s3_s, c3_s, s4_s, c4_s, s5_s, c5_s;

  // Partial products, one row per bit of b
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        pp_s[i] = 16'(a) << i;
      end else begin
        pp_s[i] = 16'h0000;
      end
    end
  end

  // Reduction tree: 8 -> 6 -> 4 -> 3 -> 2 rows, then one carry-propagate add
  assign s0_s = csa_sum(pp_s[0], pp_s[1], pp_s[2]);
  assign c0_s = csa_carry(pp_s[0], pp_s[1], pp_s[2]);
  assign s1_s = csa_sum(pp_s[3], pp_s[4], pp_s[5]);
  assign c1_s = csa_carry(pp_s[3], pp_s[4], pp_s[5]);
  assign s2_s = csa_sum(s0_s, c0_s, s1_s);
  assign c2_s = csa_carry(s0_s, c0_s, s1_s);
  assign s3_s = csa_sum(c1_s, pp_s[6], pp_s[7]);
  assign c3_s = csa_carry(c1_s, pp_s[6], pp_s[7]);
  assign s4_s = csa_sum(s2_s, c2_s, s3_s);
  assign c4_s = csa_carry(s2_s, c2_s, s3_s);
  assign s5_s = csa_sum(s4_s, c4_s, c3_s);
  assign c5_s = csa_carry(s4_s, c4_s, c3_s);
  assign p    = s5_s + c5_s;

endmodule

module wallace_mult_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_product,
  output logic                 busy,
  output logic [CNT_W-1:0]     done_count
);

  localparam int SLOTS = 1 << ID_W;

  logic              iss_v_r;
  logic [7:0]        iss_a_r, iss_b_r;
  logic [ID_W-1:0]   iss_id_r;
  logic [ID_W-1:0]   ptr_r;
  logic              out_free_s, iss_free_s;
  logic [SLOTS-1:0]  valid_pad_s, grant_pad_s;
  logic              grant_any_s;
  logic [ID_W-1:0]   grant_idx_s, ptr_next_s;
  logic [ID_W:0]     cand_s;
  logic [7:0]        a_lane_s [SLOTS];
  logic [7:0]        b_lane_s [SLOTS];
  logic [15:0]       mult_p_s;

  // Tag space may exceed NUM_REQ; unused lanes read as zero
  for (genvar g = 0; g < SLOTS; g++) begin : g_lane
    if (g < NUM_REQ) begin : g_used
      assign a_lane_s[g] = req_a[8*g+7:8*g];
      assign b_lane_s[g] = req_b[8*g+7:8*g];
    end else begin : g_unused
      assign a_lane_s[g] = 8'h00;
      assign b_lane_s[g] = 8'h00;
    end
  end

  assign valid_pad_s = SLOTS'(req_valid);
  assign out_free_s  = !rsp_valid || rsp_ready;
  assign iss_free_s  = !iss_v_r || out_free_s;
  assign busy        = iss_v_r || rsp_valid;

  // Round-robin search starting at the pointer, wrapping modulo NUM_REQ
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    if (iss_free_s && !rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand_s = {1'b0, ptr_r} + (ID_W+1)'(k);
        if (cand_s >= (ID_W+1)'(NUM_REQ)) begin
          cand_s = cand_s - (ID_W+1)'(NUM_REQ);
        end else begin
          cand_s = cand_s;
        end
        if (!grant_any_s && valid_pad_s[cand_s[ID_W-1:0]]) begin
          grant_any_s = 1'b1;
          grant_idx_s = cand_s[ID_W-1:0];
        end else begin
          grant_any_s = grant_any_s;
        end
      end
    end else begin
      grant_any_s = 1'b0;
    end
  end

  // One-hot grant decode and next pointer
  always_comb begin
    grant_pad_s = '0;
    if (grant_any_s) begin
      grant_pad_s[grant_idx_s] = 1'b1;
    end else begin
      grant_pad_s = '0;
    end
    if (grant_idx_s == ID_W'(NUM_REQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = grant_idx_s + ID_W'(1);
    end
  end

  assign req_ready = grant_pad_s[NUM_REQ-1:0];

  Wallace_Tree_Multiplier_8x8 u_mult (
    .a (iss_a_r),
    .b (iss_b_r),
    .p (mult_p_s)
  );

  // Issue stage and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_v_r  <= 1'b0;
      iss_a_r  <= 8'h00;
      iss_b_r  <= 8'h00;
      iss_id_r <= '0;
      ptr_r    <= '0;
    end else if (grant_any_s) begin
      iss_v_r  <= 1'b1;
      iss_a_r  <= a_lane_s[grant_idx_s];
      iss_b_r  <= b_lane_s[grant_idx_s];
      iss_id_r <= grant_idx_s;
      ptr_r    <= ptr_next_s;
    end else if (out_free_s) begin
      iss_v_r  <= 1'b0;
    end
  end

  // Output stage: holds steady while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid   <= 1'b0;
      rsp_product <= 16'h0000;
      rsp_id      <= '0;
    end else if (out_free_s) begin
      rsp_valid <= iss_v_r;
      if (iss_v_r) begin
        rsp_product <= mult_p_s;
        rsp_id      <= iss_id_r;
      end
    end
  end

  // Completed-response counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_count <= '0;
    end else if (rsp_valid && rsp_ready) begin
      done_count <= done_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wallace_mult_rr_arbiter.sv
// Self-checking bench: vector table, directed multi-cycle sequences and a
// randomized run scored against a queue-based transaction model.

module tb_wallace_mult_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 6;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_a, req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 rsp_valid, rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [15:0]          rsp_product;
  logic                 busy;
  logic [CNT_W-1:0]     done_count;

  int tests = 0;
  int fails = 0;

  wallace_mult_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .busy        (busy),
    .done_count  (done_count)
  );

  always #5 clk = ~clk;

  typedef struct { int id; int a; int b; int prod; } vec_t;
  typedef struct { int id; int prod; int c; } op_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_lane(input int i, input int a, input int b);
    req_a[8*i +: 8] = 8'(a);
    req_b[8*i +: 8] = 8'(b);
  endtask

  vec_t vecs[6];
  int   exp_dc;
  int   got[$];
  int   next_op;
  int   bp_a[3], bp_b[3], bp_p[3];

  // random-run model state
  op_t  q[$];
  int   ptr, dcnt, pv[NUM_REQ], pa[NUM_REQ], pb[NUM_REQ];

  initial begin
    vecs[0] = '{2, 13, 11, 143};
    vecs[1] = '{0, 255, 255, 65025};
    vecs[2] = '{3, 0, 200, 0};
    vecs[3] = '{1, 1, 128, 128};
    vecs[4] = '{2, 128, 2, 256};
    vecs[5] = '{3, 17, 15, 255};
    bp_a = '{5, 9, 200};
    bp_b = '{7, 9, 3};
    bp_p = '{35, 81, 600};

    // reset state, with requests present
    rst = 1'b1; req_valid = 4'b1111; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done_count, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_product", rsp_product, 0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // table: single ops, 2-cycle latency, one-cycle response
    exp_dc = 0;
    foreach (vecs[v]) begin
      req_valid = 4'(1 << vecs[v].id);
      set_lane(vecs[v].id, vecs[v].a, vecs[v].b);
      rsp_ready = 1'b1;
      #1;
      chk("tbl_grant", req_ready, 1 << vecs[v].id);
      tick();
      req_valid = '0;
      #1;
      chk("tbl_rv_early", rsp_valid, 0);
      chk("tbl_busy", busy, 1);
      tick();
      #1;
      chk("tbl_rv", rsp_valid, 1);
      chk("tbl_id", rsp_id, vecs[v].id);
      chk("tbl_product", rsp_product, vecs[v].prod);
      tick();
      #1;
      exp_dc++;
      chk("tbl_rv_one_cycle", rsp_valid, 0);
      chk("tbl_done", done_count, exp_dc);
      chk("tbl_idle", busy, 0);
    end

    // back-to-back boundary operands from requester 0
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        req_valid = 4'b0001;
        set_lane(0, vecs[k+1].a, vecs[k+1].b);
      end else begin
        req_valid = '0;
      end
      #1;
      if (k < 4) chk("b2b_grant", req_ready, 1);
      if (k >= 2 && k < 6) begin
        chk("b2b_rv", rsp_valid, 1);
        chk("b2b_id", rsp_id, 0);
        chk("b2b_product", rsp_product, vecs[k-1].prod);
      end else begin
        chk("b2b_rv_idle", rsp_valid, 0);
      end
      tick();
    end
    #1;
    chk("b2b_done", done_count, exp_dc + 4);

    // round robin with all requesters valid
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) set_lane(i, i + 1, 3);
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("rr_grant", req_ready, 1 << (k % 4));
      if (k >= 2) begin
        chk("rr_rv", rsp_valid, 1);
        chk("rr_id", rsp_id, (k - 2) % 4);
        chk("rr_product", rsp_product, 3 * ((k - 2) % 4 + 1));
      end
      tick();
    end

    // backpressure: three ops, consumer stalled for five cycles
    do_reset();
    next_op = 0;
    got.delete();
    for (int k = 0; k < 15; k++) begin
      rsp_ready = (k >= 5);
      if (next_op < 3) begin
        req_valid = 4'b0001;
        set_lane(0, bp_a[next_op], bp_b[next_op]);
      end else begin
        req_valid = '0;
      end
      #1;
      if (k < 5) chk("bp_grant", req_ready, (k < 2) ? 1 : 0);
      if (k >= 2 && k < 5) begin
        chk("bp_hold_rv", rsp_valid, 1);
        chk("bp_hold_id", rsp_id, 0);
        chk("bp_hold_product", rsp_product, 35);
        chk("bp_busy", busy, 1);
      end
      if (k >= 5 && rsp_valid) got.push_back(int'(rsp_product));
      if (req_valid[0] && req_ready[0]) next_op++;
      tick();
    end
    chk("bp_count", got.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < got.size()) chk("bp_order", got[i], bp_p[i]);
      else chk("bp_missing", -1, bp_p[i]);
    end
    #1;
    chk("bp_done", done_count, 3);

    // pointer skip: move pointer to 2, then requesters 1 and 3
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0010; set_lane(1, 2, 2);
    #1; chk("skip_setup", req_ready, 4'b0010);
    tick(); req_valid = '0; tick(); tick();
    req_valid = 4'b1010; set_lane(3, 4, 4);
    #1; chk("skip_first", req_ready, 4'b1000);
    tick(); req_valid = 4'b0010;
    #1; chk("skip_second", req_ready, 4'b0010);
    tick(); req_valid = 4'b1111;
    #1; chk("skip_ptr_end", req_ready, 4'b0100);
    tick(); req_valid = '0; tick(); tick(); tick();

    // reset while both stages are occupied
    rsp_ready = 1'b0;
    req_valid = 4'b0001; set_lane(0, 3, 4);
    tick();
    req_valid = 4'b0100; set_lane(2, 6, 7);
    tick();
    req_valid = '0;
    #1;
    chk("mid_pre_rv", rsp_valid, 1);
    chk("mid_pre_busy", busy, 1);
    chk("mid_pre_done", done_count, 4);
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("mid_rv", rsp_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done_count, 0);
    chk("mid_ready", req_ready, 0);
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1010; set_lane(1, 10, 10);
    #1; chk("mid_after_grant", req_ready, 4'b0010);
    tick(); req_valid = '0;
    #1; chk("mid_no_stale", rsp_valid, 0);
    tick();
    #1;
    chk("mid_after_rv", rsp_valid, 1);
    chk("mid_after_id", rsp_id, 1);
    chk("mid_after_product", rsp_product, 100);

    // randomized run against the transaction model
    do_reset();
    q.delete();
    ptr = 0; dcnt = 0;
    for (int i = 0; i < NUM_REQ; i++) pv[i] = 0;
    for (int cyc = 0; cyc < 3020; cyc++) begin
      int  g;
      int  exp_grant;
      int  exp_rv;
      bit  stall;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pv[i] && cyc < 3000 && $urandom_range(0, 99) < 45) begin
          pv[i] = 1;
          case ($urandom_range(0, 4))
            0:       begin pa[i] = 255; pb[i] = 255; end
            1:       begin pa[i] = 0;   pb[i] = $urandom_range(0, 255); end
            default: begin pa[i] = $urandom_range(0, 255); pb[i] = $urandom_range(0, 255); end
          endcase
        end
        req_valid[i] = pv[i][0];
        set_lane(i, pa[i], pb[i]);
      end
      rsp_ready = (cyc >= 3000) || ($urandom_range(0, 99) < 65);
      #1;
      stall = (q.size() == 2) && !rsp_ready;
      g = -1;
      if (!stall) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (g < 0 && pv[(ptr + k) % NUM_REQ] != 0) g = (ptr + k) % NUM_REQ;
        end
      end
      exp_grant = (g >= 0) ? (1 << g) : 0;
      exp_rv = (q.size() > 0 && q[0].c <= cyc - 2) ? 1 : 0;
      chk("rnd_grant", req_ready, exp_grant);
      chk("rnd_busy", busy, (q.size() > 0) ? 1 : 0);
      chk("rnd_done", done_count, dcnt);
      chk("rnd_rv", rsp_valid, exp_rv);
      if (exp_rv != 0 && rsp_valid) begin
        chk("rnd_id", rsp_id, q[0].id);
        chk("rnd_product", rsp_product, q[0].prod);
      end
      if (exp_rv != 0 && rsp_ready) begin
        void'(q.pop_front());
        dcnt = (dcnt + 1) % (1 << CNT_W);
      end
      if (g >= 0) begin
        q.push_back('{g, pa[g] * pb[g], cyc});
        ptr = (g + 1) % NUM_REQ;
        pv[g] = 0;
      end
      tick();
    end
    chk("rnd_drained", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wallace_mult_rr_arbiter.md
Name: wallace_mult_rr_arbiter

Overview:
- Shares one combinational 8x8 Wallace-tree multiplier (Wallace_Tree_Multiplier_8x8) between NUM_REQ requesters.
- Grants are round-robin over valid/ready request channels.
- Operands are registered into an issue stage; the product is registered into an output stage. Results return on a single tagged response channel with backpressure.
- Sits between client blocks, such as filter and MAC sequencers, and the shared multiplier datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester tag; must satisfy 2**ID_W >= NUM_REQ.
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_a  input  8*NUM_REQ  operand A; requester i uses bits [8i+7:8i].
- req_b  input  8*NUM_REQ  operand B; same packing as req_a.
- req_ready  output  NUM_REQ  one-hot or zero grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_W  index of requester that issued the operation.
- rsp_product  output  16  unsigned product A*B.
- busy  output  1  high when the issue stage or output stage holds an operation.
- done_count  output  CNT_W  count of responses accepted by the consumer (rsp_valid & rsp_ready); wraps modulo 2**CNT_W.

Behaviour:
- Reset (async, rst=1): issue stage empty; rsp_valid=0; rsp_id=0; rsp_product=0; done_count=0; busy=0; round-robin pointer=0. req_ready=0 while rst=1.
- Pipeline stages:
  - Issue stage (iss_v, iss_a, iss_b, iss_id) drives the multiplier inputs.
  - Output stage (rsp_valid, rsp_product, rsp_id) captures the multiplier result.
- out_free = !rsp_valid | rsp_ready.
- iss_free = !iss_v | out_free.
- Arbitration (combinational):
  - When iss_free=1, grant the first i with req_valid[i]=1, searching from pointer upward and wrapping modulo NUM_REQ. Set req_ready[i]=1 for that i only.
  - When iss_free=0, req_ready=0.
  - req_ready never depends on req_a/req_b.
- On a grant to index g: load iss_a, iss_b, iss_id=g and set iss_v=1; pointer <= (g+1) mod NUM_REQ.
- With no grant: pointer holds. If out_free, iss_v <= 0.
- When out_free and iss_v: rsp_valid <= 1, rsp_product <= multiplier(iss_a, iss_b), rsp_id <= iss_id.
- When out_free and !iss_v: rsp_valid <= 0. rsp_product and rsp_id hold their last values.
- When !out_free: both stages hold and no grants are issued. The response channel stays stable while rsp_valid & !rsp_ready.
- Latency and throughput:
  - Accept at edge N gives rsp_valid at edge N+1, i.e. visible in the cycle after the issue cycle (2-cycle request-to-response).
  - Sustained throughput is 1 op/cycle with rsp_ready held high.
- Fairness: with all NUM_REQ requesters continuously valid, each is granted exactly once per NUM_REQ grants.
- Simultaneous events:
  - A grant and a response drain in the same cycle are both legal.
  - A full pipeline with rsp_ready=1 accepts a new request in that same cycle.
- Product arithmetic: unsigned, 16-bit, no truncation (255*255=65025).
- busy = iss_v | rsp_valid.
- done_count increments by 1 on each rsp_valid & rsp_ready cycle; 2**CNT_W-1 wraps to 0.
- Requester protocol: once asserted, req_valid and operands stay stable until accepted. The block does not check this.
- Reset mid-operation: in-flight operations are discarded with no response, and the pointer returns to 0.

Test Plan:
- Single op: after reset, requester 2 presents A=0x0D, B=0x0B with rsp_ready=1 -> req_ready=0b0100 the same cycle; 2 cycles later rsp_valid=1, rsp_id=2, rsp_product=143 for one cycle; done_count=1.
- Boundary operands: (255,255) -> 65025; (0,200) -> 0; (1,128) -> 128; (128,2) -> 256, back-to-back from requester 0 -> four responses on consecutive cycles, in order.
- Round robin: all four requesters valid continuously, A=i+1, B=3 -> grant order 0,1,2,3,0,1,...; products 3,6,9,12 repeating; ids match.
- Backpressure: 3 ops issued, rsp_ready low 5 cycles -> at most 2 ops held; req_ready=0 while stalled; rsp_id and rsp_product stable; on release all 3 delivered, in order, with no loss or duplication.
- Pointer skip: only requesters 1 and 3 valid, pointer=2 -> grant 3 then 1; pointer ends at 2.
- Reset mid-flight: assert rst with iss_v=1 and rsp_valid=1 -> rsp_valid, busy and done_count go to 0 immediately (async); after release, a new op on requester 1 is granted first.
